// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx_if
// Description : Data-memory bus bundle between the core and the UART responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_uart_tx_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 10
);
    logic                       re;
    logic                       we;
    logic [3:0]                 byteEn;
    logic [DATA_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]      dataIn;
    logic [DATA_WIDTH-1:0]      dataOut;

    modport master (output re, output we, output byteEn, output addr, output dataIn,
                    input  dataOut);
    modport slave  (input  re, input  we, input  byteEn, input  addr, input  dataIn,
                    output dataOut);
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter int                         DATA_WIDTH      = 32,
    parameter int                         DATA_ADDR_WIDTH = 10,
    parameter logic [DATA_ADDR_WIDTH-1:0] BASE_ADDR       = 10'h010,
    parameter int                         FIFO_DEPTH      = 4,
    parameter logic [15:0]                RESET_BAUD_DIV  = 16'd434
) (
    input  logic                clk,
    input  logic                rst,
    mmio_uart_tx_if.slave       bus,
    output logic                txd,
    output logic                irq
);
    localparam int c_ptrW = $clog2(FIFO_DEPTH);
    localparam int c_cntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state, w_nextState;
    logic [15:0]         r_baudDiv;
    logic [15:0]         r_bitCnt, w_nextCnt;
    logic [2:0]          r_bitIdx, w_nextIdx;
    logic [7:0]          r_shift, w_nextShift;
    logic                r_overflow;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ptrW-1:0]   r_wrPtr, r_rdPtr;
    logic [c_cntW-1:0]   r_count;

    logic                w_sel, w_wr, w_rd, w_pushReq, w_push, w_pop;
    logic                w_full, w_empty, w_ovfClr;
    logic [1:0]          w_regIdx;
    logic [15:0]         w_period, w_reload;
    logic [DATA_WIDTH-1:0] w_rdData;
    logic                w_unused;

    assign w_sel     = (bus.addr[DATA_ADDR_WIDTH-1:4] == BASE_ADDR[DATA_ADDR_WIDTH-1:4]);
    assign w_regIdx  = bus.addr[3:2];
    assign w_wr      = w_sel && bus.we;
    assign w_rd      = w_sel && bus.re && !bus.we;
    assign w_full    = (r_count == c_cntW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pushReq = w_wr && (w_regIdx == 2'd0) && bus.byteEn[0];
    // A full FIFO still takes the byte when the transmitter frees a slot this cycle.
    assign w_push    = w_pushReq && (!w_full || w_pop);
    assign w_ovfClr  = w_wr && (w_regIdx == 2'd1) && bus.byteEn[1] && bus.dataIn[8];
    assign w_period  = (r_baudDiv == 16'd0) ? 16'd1 : r_baudDiv;
    assign w_reload  = w_period - 16'd1;
    assign irq       = w_empty && (r_state == S_IDLE);
    assign w_unused  = &{1'b0, bus.dataIn[DATA_WIDTH-1:16], bus.byteEn[3:2], bus.addr[1:0]};

    always_comb begin
        w_rdData = '0;
        case (w_regIdx)
            2'd1: begin
                w_rdData[0]   = (r_state != S_IDLE);
                w_rdData[1]   = w_full;
                w_rdData[2]   = w_empty;
                w_rdData[6:4] = 3'(r_count);
                w_rdData[8]   = r_overflow;
            end
            2'd2:    w_rdData[15:0] = r_baudDiv;
            default: w_rdData = '0;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_bitCnt;
        w_nextIdx   = r_bitIdx;
        w_nextShift = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nextShift = r_mem[r_rdPtr];
                    w_nextCnt   = w_reload;
                    w_nextState = S_START;
                end
            end
            S_START: begin
                if (r_bitCnt == 16'd0) begin
                    w_nextCnt   = w_reload;
                    w_nextIdx   = 3'd0;
                    w_nextState = S_DATA;
                end else begin
                    w_nextCnt = r_bitCnt - 16'd1;
                end
            end
            S_DATA: begin
                if (r_bitCnt == 16'd0) begin
                    w_nextCnt = w_reload;
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = S_STOP;
                    end else begin
                        w_nextIdx   = r_bitIdx + 3'd1;
                        w_nextShift = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_nextCnt = r_bitCnt - 16'd1;
                end
            end
            S_STOP: begin
                if (r_bitCnt == 16'd0) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_nextShift = r_mem[r_rdPtr];
                        w_nextCnt   = w_reload;
                        w_nextState = S_START;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end else begin
                    w_nextCnt = r_bitCnt - 16'd1;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_state)
            S_START: txd = 1'b0;
            S_DATA:  txd = r_shift[0];
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= bus.dataIn[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bitCnt    <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
            r_baudDiv   <= RESET_BAUD_DIV;
            r_overflow  <= 1'b0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            bus.dataOut <= '0;
        end else begin
            r_state  <= w_nextState;
            r_bitCnt <= w_nextCnt;
            r_bitIdx <= w_nextIdx;
            r_shift  <= w_nextShift;
            if (w_rd) begin
                bus.dataOut <= w_rdData;
            end
            if (w_wr && (w_regIdx == 2'd2)) begin
                if (bus.byteEn[0]) r_baudDiv[7:0]  <= bus.dataIn[7:0];
                if (bus.byteEn[1]) r_baudDiv[15:8] <= bus.dataIn[15:8];
            end
            if (w_pushReq && !w_push) begin
                r_overflow <= 1'b1;
            end else if (w_ovfClr) begin
                r_overflow <= 1'b0;
            end
            if (w_push) r_wrPtr <= r_wrPtr + c_ptrW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + c_ptrW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cntW'(1);
                2'b01:   r_count <= r_count - c_cntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Directed self-checking bench for mmio_uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic        txd;
    logic        irq;
    int          nChecks = 0;
    int          nPass   = 0;
    bit          expQ[$];
    logic [31:0] rdData;

    mmio_uart_tx_if #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(10)) busIf ();

    mmio_uart_tx #(
        .DATA_WIDTH      (32),
        .DATA_ADDR_WIDTH (10),
        .BASE_ADDR       (10'h010),
        .FIFO_DEPTH      (4),
        .RESET_BAUD_DIV  (16'd434)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf),
        .txd (txd),
        .irq (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    // Caller is at a falling edge; the access lands on the next rising edge.
    task automatic busWrite(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        busIf.addr   = a;
        busIf.dataIn = d;
        busIf.byteEn = be;
        busIf.re     = 1'b0;
        busIf.we     = 1'b1;
        @(negedge clk);
        busIf.we     = 1'b0;
    endtask

    task automatic busRead(input logic [9:0] a, output logic [31:0] d);
        busIf.addr = a;
        busIf.re   = 1'b1;
        busIf.we   = 1'b0;
        @(negedge clk);
        busIf.re   = 1'b0;
        d          = busIf.dataOut;
    endtask

    task automatic addBits(input bit lv, input int n);
        repeat (n) expQ.push_back(lv);
    endtask

    task automatic addFrame(input logic [7:0] b, input int p);
        addBits(1'b0, p);
        for (int i = 0; i < 8; i++) addBits(b[i], p);
        addBits(1'b1, p);
    endtask

    task automatic runTxd(input string tag);
        int bad    = 0;
        int irqBad = 0;
        foreach (expQ[i]) begin
            @(negedge clk);
            if (txd !== expQ[i]) bad++;
            if (irq !== 1'b0) irqBad++;
        end
        check({tag, " txd mismatches"}, bad, 0);
        check({tag, " irq during frame"}, irqBad, 0);
        expQ.delete();
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        check({tag, " idle txd"}, {31'b0, txd}, 32'd1);
        check({tag, " idle irq"}, {31'b0, irq}, 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        busIf.re = 1'b0; busIf.we = 1'b0; busIf.byteEn = 4'h0;
        busIf.addr = '0; busIf.dataIn = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        busRead(10'h014, rdData);
        check("reset STATUS", rdData, 32'h0000_0004);
        check("reset txd", {31'b0, txd}, 32'd1);
        check("reset irq", {31'b0, irq}, 32'd1);
        busRead(10'h018, rdData);
        check("reset BAUDDIV", rdData, 32'd434);

        busWrite(10'h018, 32'd4, 4'hF);
        busRead(10'h018, rdData);
        check("BAUDDIV=4 readback", rdData, 32'd4);
        busWrite(10'h010, 32'hA5, 4'h1);
        check("txd high until pop", {31'b0, txd}, 32'd1);
        addFrame(8'hA5, 4);
        runTxd("frame A5");
        checkIdle("after A5");

        busWrite(10'h018, 32'd2, 4'hF);
        busWrite(10'h010, 32'h01, 4'h1);
        for (int k = 1; k <= 5; k++) addFrame(8'(k), 2);
        fork
            runTxd("five frames");
            begin
                for (int k = 2; k <= 6; k++) busWrite(10'h010, 32'(k), 4'h1);
                busRead(10'h014, rdData);
                check("STATUS full+overflow", rdData, 32'h0000_0143);
                busWrite(10'h014, 32'h100, 4'b0010);
                busRead(10'h014, rdData);
                check("STATUS overflow cleared", rdData, 32'h0000_0043);
            end
        join
        checkIdle("after five frames");

        busWrite(10'h018, 32'd8, 4'hF);
        busWrite(10'h010, 32'h3C, 4'h1);
        b = 8'h3C;
        addBits(1'b0, 8);
        for (int i = 0; i < 4; i++) addBits(b[i], 8);
        for (int i = 4; i < 8; i++) addBits(b[i], 2);
        addBits(1'b1, 2);
        fork
            runTxd("baud change mid bit3");
            begin
                repeat (35) @(negedge clk);
                busWrite(10'h018, 32'd2, 4'hF);
            end
        join
        checkIdle("after baud change");

        busWrite(10'h018, 32'hABCD_1278, 4'b0001);
        busRead(10'h018, rdData);
        check("BAUDDIV low byte only", rdData, 32'h0000_0078);
        busWrite(10'h018, 32'h0000_3400, 4'b0010);
        busRead(10'h018, rdData);
        check("BAUDDIV high byte only", rdData, 32'h0000_3478);
        busRead(10'h000, rdData);
        check("unselected read holds", rdData, 32'h0000_3478);
        busRead(10'h010, rdData);
        check("TXDATA reads 0", rdData, 32'h0);
        busRead(10'h01C, rdData);
        check("reg 0xC reads 0", rdData, 32'h0);
        busWrite(10'h010, 32'h77, 4'b0010);
        busRead(10'h014, rdData);
        check("no push without byteEn0", rdData, 32'h0000_0004);

        busWrite(10'h018, 32'd0, 4'hF);
        busWrite(10'h010, 32'h96, 4'h1);
        addFrame(8'h96, 1);
        runTxd("BAUDDIV=0 frame");
        checkIdle("after BAUDDIV=0");

        busWrite(10'h018, 32'd4, 4'hF);
        busWrite(10'h010, 32'h00, 4'h1);
        busWrite(10'h010, 32'h55, 4'h1);
        repeat (25) @(negedge clk);
        check("bit5 low before reset", {31'b0, txd}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("txd high on reset", {31'b0, txd}, 32'd1);
        check("irq high on reset", {31'b0, irq}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        busRead(10'h018, rdData);
        check("BAUDDIV after reset", rdData, 32'd434);
        busRead(10'h014, rdData);
        check("STATUS after reset", rdData, 32'h0000_0004);
        begin
            int bad = 0;
            repeat (60) begin
                @(negedge clk);
                if (txd !== 1'b1 || irq !== 1'b1) bad++;
            end
            check("no frame after reset", bad, 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
`default_nettype wire
